// File: rtl/conv3x3_stream_top.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_stream_top
// Description : Streaming 3x3 convolution over raster-scan greyscale pixels.
//               Two line buffers and a 3x3 window feed a registered multiply
//               stage, a two-level registered adder tree and a shift/clamp
//               output register. Latency: 4 clocks from the accepting edge.
//               Optional macro CONV_ROUND_EN adds 2^(SHIFT-1) before the shift.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_stream_top #(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32,
  parameter int IMG_W  = 640,
  parameter int SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     valid_in,
  input  logic [PIX_W-1:0]         px_in,
  input  logic                     kernel_wr,
  input  logic [3:0]               kernel_addr,
  input  logic signed [COEF_W-1:0] kernel_data,
  output logic                     valid_out,
  output logic [PIX_W-1:0]         px_out
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);
  localparam logic signed [ACC_W-1:0] C_PIX_MAX = ACC_W'((64'd1 << PIX_W) - 64'd1);
  localparam logic signed [ACC_W-1:0] C_RND =
    (SHIFT > 0) ? ACC_W'(64'd1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

  // rstn is active-high despite its name
  logic                     w_rst;
  assign w_rst = rstn;

  logic [COL_W-1:0]         r_col;
  logic [1:0]               r_row;
  logic signed [COEF_W-1:0] r_coef [0:8];

  logic [PIX_W-1:0]         r_lb1 [0:IMG_W-1];  // line y-1
  logic [PIX_W-1:0]         r_lb2 [0:IMG_W-1];  // line y-2
  logic [PIX_W-1:0]         r_win [0:8];        // index 3*row + col

  logic signed [ACC_W-1:0]  w_prod [0:8];
  logic signed [ACC_W-1:0]  r_prod [0:8];
  logic signed [ACC_W-1:0]  r_part [0:2];
  logic signed [ACC_W-1:0]  r_sum;
  logic signed [ACC_W-1:0]  w_rnd;
  logic signed [ACC_W-1:0]  w_shift;
  logic [PIX_W-1:0]         w_clamp;

  logic r_v0, r_v1, r_v2, r_v3;

`ifdef CONV_ROUND_EN
  assign w_rnd = C_RND;
`else
  assign w_rnd = '0;
`endif

  // Counters, coefficient bank and pipeline valid chain
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_col <= '0;
      r_row <= '0;
      for (int i = 0; i < 9; i++) r_coef[i] <= '0;
      r_v0  <= 1'b0;
      r_v1  <= 1'b0;
      r_v2  <= 1'b0;
      r_v3  <= 1'b0;
    end else begin
      if (kernel_wr && (kernel_addr <= 4'd8)) r_coef[kernel_addr] <= kernel_data;
      if (valid_in) begin
        if (r_col == C_COL_LAST) begin
          r_col <= '0;
          if (r_row != 2'd2) r_row <= r_row + 2'd1;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end
      r_v0 <= valid_in && (r_col >= C_COL_TWO) && (r_row == 2'd2);
      r_v1 <= r_v0;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Line buffers and window shift; contents are qualified by the valid chain
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb1[r_col] <= px_in;
      r_lb2[r_col] <= r_lb1[r_col];
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
      end
      r_win[2] <= r_lb2[r_col];
      r_win[5] <= r_lb1[r_col];
      r_win[8] <= px_in;
    end
  end

  // Pixels are unsigned: zero-extend before the signed multiply
  for (genvar i = 0; i < 9; i++) begin : g_mac
    logic signed [ACC_W-1:0] w_px_ext;
    logic signed [ACC_W-1:0] w_cf_ext;
    assign w_px_ext  = {{(ACC_W-PIX_W){1'b0}}, r_win[i]};
    assign w_cf_ext  = {{(ACC_W-COEF_W){r_coef[i][COEF_W-1]}}, r_coef[i]};
    assign w_prod[i] = w_px_ext * w_cf_ext;
  end

  // Multiply stage, per-row partial sums, then the final sum (with rounding)
  always_ff @(posedge clk) begin
    for (int i = 0; i < 9; i++) r_prod[i] <= w_prod[i];
    for (int g = 0; g < 3; g++) r_part[g] <= r_prod[3*g] + r_prod[3*g+1] + r_prod[3*g+2];
    r_sum <= r_part[0] + r_part[1] + r_part[2] + w_rnd;
  end

  assign w_shift = r_sum >>> SHIFT;

  // Saturate the scaled sum into the unsigned pixel range
  always_comb begin
    w_clamp = w_shift[PIX_W-1:0];
    if (w_shift[ACC_W-1])          w_clamp = '0;
    else if (w_shift > C_PIX_MAX)  w_clamp = '1;
  end

  // Output register; px_out holds between valid results
  always_ff @(posedge clk) begin
    if (w_rst) begin
      valid_out <= 1'b0;
      px_out    <= '0;
    end else begin
      valid_out <= r_v3;
      if (r_v3) px_out <= w_clamp;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_stream_top
// Description : Directed self-checking bench for conv3x3_stream_top (IMG_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream_top;

  logic               clk = 1'b0;
  logic               rstn = 1'b1;
  logic               valid_in = 1'b0;
  logic [7:0]         px_in = '0;
  logic               kernel_wr = 1'b0;
  logic [3:0]         kernel_addr = '0;
  logic signed [15:0] kernel_data = '0;
  logic               valid_out;
  logic [7:0]         px_out;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int q_val[$];
  int q_edge[$];
  int e_val[$];
  int e_edge[$];

  conv3x3_stream_top #(
    .PIX_W(8), .COEF_W(16), .ACC_W(32), .IMG_W(8), .SHIFT(8)
  ) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .px_in(px_in),
    .kernel_wr(kernel_wr), .kernel_addr(kernel_addr), .kernel_data(kernel_data),
    .valid_out(valid_out), .px_out(px_out)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number N, cyc reads N at the following negedge
  always @(posedge clk) cyc <= cyc + 1;

  // Output capture
  always @(negedge clk) begin
    if (valid_out) begin
      q_val.push_back(int'(px_out));
      q_edge.push_back(cyc);
    end
  end

  task automatic clear_queues();
    q_val.delete(); q_edge.delete(); e_val.delete(); e_edge.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b1; valid_in = 1'b0; kernel_wr = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    clear_queues();
  endtask

  task automatic write_coef(input int addr, input int data);
    @(negedge clk);
    kernel_wr = 1'b1; kernel_addr = 4'(addr); kernel_data = 16'(data);
    @(negedge clk);
    kernel_wr = 1'b0;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 9; i++) write_coef(i, v);
  endtask

  // kind 0: constant cval, expect expv; 1: ramp, expect centre pixel; 2: ramp, expect expv
  task automatic stream(input int kind, input int cval, input int expv,
                        input int npix, input bit gap, input bit drain);
    int x, y, p, acc;
    for (int i = 0; i < npix; i++) begin
      x = i % 8; y = i / 8;
      p = (kind == 0) ? cval : ((x + 8*y) % 256);
      @(negedge clk);
      valid_in = 1'b1; px_in = 8'(p);
      acc = cyc + 1;
      if (x >= 2 && y >= 2) begin
        e_val.push_back((kind == 1) ? (((x-1) + 8*(y-1)) % 256) : expv);
        e_edge.push_back(acc + 4);
      end
      if (gap) begin
        @(negedge clk);
        valid_in = 1'b0;
      end
    end
    if (drain) begin
      @(negedge clk);
      valid_in = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    n_checks++;
    if (px_out !== 8'd0) begin n_errors++; $display("FAIL reset_px: got %0d expected 0", px_out); end
  endtask

  task automatic test_box_const();
    do_reset();
    set_all(1);
    stream(0, 200, 7, 32, 1'b0, 1'b1);  // 1800>>8=7, rounded 1928>>8=7
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL box_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== e_val[i]) begin n_errors++; $display("FAIL box_val[%0d]: got %0d expected %0d", i, q_val[i], e_val[i]); end
      n_checks++;
      if (q_edge[i] !== e_edge[i]) begin n_errors++; $display("FAIL box_edge[%0d]: got %0d expected %0d", i, q_edge[i], e_edge[i]); end
    end
  endtask

  task automatic test_identity_ramp();
    do_reset();
    write_coef(4, 256);
    stream(1, 0, 0, 32, 1'b0, 1'b1);
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL ident_count: got %0d expected 12", q_val.size()); end
    n_checks++;
    if (q_val.size() > 0 && q_val[0] !== 9) begin n_errors++; $display("FAIL ident_first: got %0d expected 9", q_val[0]); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== e_val[i]) begin n_errors++; $display("FAIL ident_val[%0d]: got %0d expected %0d", i, q_val[i], e_val[i]); end
      n_checks++;
      if (q_edge[i] !== e_edge[i]) begin n_errors++; $display("FAIL ident_edge[%0d]: got %0d expected %0d", i, q_edge[i], e_edge[i]); end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    set_all(-1);
    stream(0, 100, 0, 32, 1'b0, 1'b1);  // -900 -> 0
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL clamp_lo_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== 0) begin n_errors++; $display("FAIL clamp_lo_val[%0d]: got %0d expected 0", i, q_val[i]); end
    end
    do_reset();
    write_coef(4, 32767);
    stream(0, 255, 255, 32, 1'b0, 1'b1);  // 8355585>>8 = 32639 -> 255
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL clamp_hi_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== 255) begin n_errors++; $display("FAIL clamp_hi_val[%0d]: got %0d expected 255", i, q_val[i]); end
    end
  endtask

  task automatic test_gapped();
    do_reset();
    set_all(1);
    stream(0, 200, 7, 32, 1'b1, 1'b1);
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL gap_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== e_val[i]) begin n_errors++; $display("FAIL gap_val[%0d]: got %0d expected %0d", i, q_val[i], e_val[i]); end
      n_checks++;
      if (q_edge[i] !== e_edge[i]) begin n_errors++; $display("FAIL gap_edge[%0d]: got %0d expected %0d", i, q_edge[i], e_edge[i]); end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    write_coef(4, 256);
    stream(1, 0, 0, 23, 1'b0, 1'b0);  // stop at x=6 of line 3, outputs in flight
    @(negedge clk);
    valid_in = 1'b0; rstn = 1'b1;
    @(negedge clk);
    rstn = 1'b0;
    n_checks++;
    if (valid_out !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b expected 0", valid_out); end
    n_checks++;
    if (px_out !== 8'd0) begin n_errors++; $display("FAIL midrst_px: got %0d expected 0", px_out); end
    clear_queues();
    repeat (6) @(negedge clk);
    n_checks++;
    if (q_val.size() !== 0) begin n_errors++; $display("FAIL midrst_flush: got %0d outputs expected 0", q_val.size()); end
    clear_queues();
    stream(2, 0, 0, 32, 1'b0, 1'b1);  // coefficients cleared -> all zero
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL restream_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== 0) begin n_errors++; $display("FAIL restream_val[%0d]: got %0d expected 0", i, q_val[i]); end
      n_checks++;
      if (q_edge[i] !== e_edge[i]) begin n_errors++; $display("FAIL restream_edge[%0d]: got %0d expected %0d", i, q_edge[i], e_edge[i]); end
    end
  endtask

  task automatic test_bad_addr();
    do_reset();
    write_coef(4, 256);
    write_coef(12, 999);
    stream(1, 0, 0, 32, 1'b0, 1'b1);
    n_checks++;
    if (q_val.size() !== 12) begin n_errors++; $display("FAIL badaddr_count: got %0d expected 12", q_val.size()); end
    for (int i = 0; i < e_val.size() && i < q_val.size(); i++) begin
      n_checks++;
      if (q_val[i] !== e_val[i]) begin n_errors++; $display("FAIL badaddr_val[%0d]: got %0d expected %0d", i, q_val[i], e_val[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_box_const();
    test_identity_ramp();
    test_clamp();
    test_gapped();
    test_mid_reset();
    test_bad_addr();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv3x3_stream_top.md
Name: conv3x3_stream_top

Overview:
- Streaming 3x3 2-D convolution engine for raster-scan greyscale pixels, one pixel per clock.
- Two internal line buffers of IMG_W pixels plus a 3x3 window register feed a pipelined multiply/adder tree using 9 runtime-programmable signed coefficients.
- The result is arithmetically shifted, clamped to pixel range, and emitted with a valid strobe.
- Sits between a pixel source (DMA/camera stream) and an output sink or capture buffer.

Parameters:
- PIX_W, 8: pixel width (unsigned).
- COEF_W, 16: coefficient width (signed two's complement).
- ACC_W, 32: accumulator width (signed); must be at least PIX_W+COEF_W+5.
- IMG_W, 640: pixels per line; line buffer depth; must be at least 3.
- SHIFT, 8: arithmetic right shift applied to the sum (fixed-point scale).

Ports:
- clk  in  1  sole clock, rising edge.
- rstn  in  1  reset. Synchronous, active-high: 1 = reset. Name kept for codebase consistency.
- valid_in  in  1  px_in is accepted on this edge. No backpressure.
- px_in  in  PIX_W  input pixel, raster order.
- kernel_wr  in  1  coefficient write strobe.
- kernel_addr  in  4  coefficient index 0..8.
- kernel_data  in  COEF_W  signed coefficient value.
- valid_out  out  1  px_out valid this cycle.
- px_out  out  PIX_W  convolved, clamped pixel.

Behaviour:
- Reset (rstn=1 at a clk edge):
  - valid_out=0, px_out=0.
  - All 9 coefficients=0; column counter=0; row counter=0; all pipeline valid bits=0.
  - Line-buffer contents need not be cleared.
  - Reset has priority over every other input, including mid-stream.
- Coefficient write: on an edge with kernel_wr=1 and kernel_addr<=8, coef[kernel_addr] takes kernel_data. Addresses 9..15 are ignored.
- Coefficient layout: addr = 3*r + c.
  - r=0 is the oldest line (y-2); r=2 is the current line.
  - c=0 is the oldest column (x-2); c=2 is the newest pixel.
  - No kernel flip (correlation form).
- Coefficient timing: a write at edge T is used by any window entering the multiply stage after T. Writes may occur while streaming.
- Accepted pixel (valid_in=1):
  - Pushed into the window and line buffers.
  - Column counter increments and wraps IMG_W-1 -> 0.
  - On wrap, the row counter increments, saturating at 2.
  - With valid_in=0 nothing shifts; gaps of any length are allowed.
- Window valid only when col>=2 and row>=2 at acceptance (full 3x3 inside the image, no padding).
  - Output count per H-line image = (IMG_W-2)*(H-2).
  - The output corresponds to centre pixel (x-1, y-1).
  - There is no frame-start input: consecutive frames are treated as one tall image. A new frame requires a reset.
- Pipeline: accept/window, registered products, registered adder tree, shift+clamp register.
  - valid_out rises exactly 4 clk cycles after the edge accepting the window-completing pixel.
  - The pipeline drains irrespective of valid_in. Fixed latency, no stalls.
- Arithmetic:
  - Each pixel is zero-extended to signed, then multiplied by its signed coefficient.
  - The 9 products are summed in signed ACC_W.
  - s = sum >>> SHIFT (arithmetic shift).
  - px_out = 0 if s<0; 2^PIX_W-1 if s>2^PIX_W-1; otherwise s.
- px_out holds its last value when valid_out=0.

Optional Feature:
- Macro CONV_ROUND_EN.
  - Defined: add 2^(SHIFT-1) to the sum before the shift (round half up); no effect when SHIFT=0.
  - Undefined: truncating arithmetic shift only.
- Latency is identical in both builds.

Test Plan:
- IMG_W=8, 4 lines of constant 200, all coefficients 1, no rounding -> exactly 12 valid_out pulses, each px_out=7 (1800>>8). With CONV_ROUND_EN: 7 (1928>>8).
- coef[4]=256, others 0, ramp image px=(x+8y) mod 256 -> px_out equals centre pixel. First output is 9 (x=1, y=1), 4 cycles after the pixel at (2,2).
- All coefficients -1, constant 100 -> px_out=0 (clamp low). coef[4]=32767, constant 255 -> px_out=255 (clamp high).
- Feed with valid_in toggling 1/0 every cycle -> same output values and count as the continuous feed; each output still 4 cycles after its completing pixel.
- Assert rstn for 1 cycle mid-line 3, then restream -> valid_out=0 next cycle. The first output again appears only after 2 full lines plus 3 pixels; coefficients read back as 0 (all outputs 0 until rewritten).
- kernel_wr with kernel_addr=12 -> no coefficient changes. Identity-kernel outputs are unaffected.
